decode_issue_stage: RTL and testbench

ID stage of the 5-stage pipelined core, between the IF/ID register and EX. Decodes the instruction and drives the register file read addresses. It also bypasses same-cycle writeback data around the register file, detects load-use hazards and owns the ID/EX pipeline register. The register file writes on the clock edge and reads combinationally, so a same-cycle WB write is invisible to reads without the bypass here.

---
 rtl/decode_issue_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   ID stage of the 5-stage core. Decodes the IF/ID instruction, drives the
//   register file read addresses, bypasses same-cycle writeback data around
//   the register file, detects load-use hazards and owns the ID/EX register.
//
// Parameters
//   XLEN            datapath width (>= 32)
//   ILLEGAL_AS_NOP  1: unsupported opcode issues with ex_illegal=1 and every
//                   data field zeroed, like a bubble that still carries ex_valid
//                   and ex_pc. 0: ex_illegal=1 with the decoded fields passed
//                   through. Controls are zero in both cases.
//
// Optional feature (macro DECODE_PERF_CNT_EN)
//   Adds saturating perf_stall_cnt / perf_flush_cnt outputs, cleared by RESET.
//
// Ports
//   CLK, RESET                 clock (rising edge), async active-high reset
//   if_id_valid/instr/pc       IF/ID register contents
//   flush                      EX resolved a taken branch/jump; kill ID
//   ReadRegister1/2            register file read addresses
//   ReadData1/2                register file read data (combinational)
//   wb_we/wb_rd/wb_data        writeback port, bypassed into the operands
//   stall_if                   hold PC and IF/ID this cycle
//   ex_*                       ID/EX pipeline register outputs
module decode_issue_stage #(
  parameter int XLEN           = 32,
  parameter int ILLEGAL_AS_NOP = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [31:0]     if_id_pc,
  input  logic            flush,
  output logic [4:0]      ReadRegister1,
  output logic [4:0]      ReadRegister2,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } idex_t;

  idex_t           r_ex;
  idex_t           w_next;
  logic [31:0]     w_ins;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;
  logic            w_legal, w_uses_rs1, w_uses_rs2, w_writes_rd;
  logic            w_mem_read, w_mem_write, w_reg_write;
  logic            w_hazard, w_bubble, w_kill_data;

  assign w_ins    = if_id_instr;
  assign w_opcode = w_ins[6:0];
  assign w_rd     = w_ins[11:7];
  assign w_rs1    = w_ins[19:15];
  assign w_rs2    = w_ins[24:20];

  assign ReadRegister1 = w_rs1;
  assign ReadRegister2 = w_rs2;

  assign w_imm_i = {{(XLEN-11){w_ins[31]}}, w_ins[30:20]};
  assign w_imm_s = {{(XLEN-11){w_ins[31]}}, w_ins[30:25], w_ins[11:7]};
  assign w_imm_b = {{(XLEN-12){w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){w_ins[31]}}, w_ins[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  always_comb begin
    w_legal     = 1'b1;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_imm       = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin w_writes_rd = 1'b1; w_imm = w_imm_u; end
      OP_JAL:           begin w_writes_rd = 1'b1; w_imm = w_imm_j; end
      OP_JALR, OP_IMM:  begin w_writes_rd = 1'b1; w_uses_rs1 = 1'b1; w_imm = w_imm_i; end
      OP_BRANCH:        begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_imm = w_imm_b; end
      OP_LOAD: begin
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
        w_mem_read  = 1'b1;
        w_imm       = w_imm_i;
      end
      OP_STORE: begin
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_mem_write = 1'b1;
        w_imm       = w_imm_s;
      end
      OP_OP:   begin w_writes_rd = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_reg_write = w_writes_rd && (w_rd != 5'd0);

  // The register file writes on the edge, so a same-cycle WB write must be
  // steered in here or the operand would be one write stale.
  assign w_rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs1) ? wb_data : ReadData1;
  assign w_rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs2) ? wb_data : ReadData2;

  // Self-limiting: the bubble inserted on the stall edge clears ex_mem_read.
  assign w_hazard = if_id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) &&
                    ((w_uses_rs1 && r_ex.rd == w_rs1) || (w_uses_rs2 && r_ex.rd == w_rs2));

  // Flush wins: the ID instruction is dead, so holding IF/ID would be wrong.
  assign stall_if    = w_hazard && !flush;
  assign w_bubble    = flush || !if_id_valid || w_hazard;
  assign w_kill_data = !w_legal && (ILLEGAL_AS_NOP != 0);

  always_comb begin
    w_next = '0;
    if (!w_bubble) begin
      w_next.valid     = 1'b1;
      w_next.pc        = if_id_pc;
      w_next.illegal   = !w_legal;
      w_next.reg_write = w_reg_write;
      w_next.mem_read  = w_mem_read;
      w_next.mem_write = w_mem_write;
      if (!w_kill_data) begin
        w_next.rs1_val  = w_rs1_val;
        w_next.rs2_val  = w_rs2_val;
        w_next.imm      = w_imm;
        w_next.rs1      = w_rs1;
        w_next.rs2      = w_rs2;
        w_next.rd       = w_rd;
        w_next.opcode   = w_opcode;
        w_next.funct3   = w_ins[14:12];
        w_next.funct7b5 = w_ins[30];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_ex <= '0;
    else       r_ex <= w_next;
  end

  assign ex_valid     = r_ex.valid;
  assign ex_pc        = r_ex.pc;
  assign ex_rs1_val   = r_ex.rs1_val;
  assign ex_rs2_val   = r_ex.rs2_val;
  assign ex_imm       = r_ex.imm;
  assign ex_rs1       = r_ex.rs1;
  assign ex_rs2       = r_ex.rs2;
  assign ex_rd        = r_ex.rd;
  assign ex_opcode    = r_ex.opcode;
  assign ex_funct3    = r_ex.funct3;
  assign ex_funct7b5  = r_ex.funct7b5;
  assign ex_reg_write = r_ex.reg_write;
  assign ex_mem_read  = r_ex.mem_read;
  assign ex_mem_write = r_ex.mem_write;
  assign ex_illegal   = r_ex.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt, r_perf_flush_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (stall_if && r_perf_stall_cnt != 32'hFFFF_FFFF) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (flush && r_perf_flush_cnt != 32'hFFFF_FFFF)    r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: stimulus drives IF/ID at the falling edge and
// pushes the expected ID/EX contents of every issued instruction into a queue;
// a separate monitor pops one entry whenever ex_valid is seen after an edge.
module tb_decode_issue_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc;
  logic        flush;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_if, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  decode_issue_stage dut (
    .CLK(CLK), .RESET(RESET), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .flush(flush), .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_if(stall_if),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5, rw, mr, mw, ill, dchk;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          m_ld_rd = 0;   // destination of an in-flight load, 0 if none
  int          m_stalls = 0;
  int          m_flushes = 0;
  logic [6:0]  OPS[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h03};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int msb);
    logic signed [31:0] t;
    t = v << (31 - msb);
    return t >>> (31 - msb);
  endfunction

  // Reference behaviour: what instruction class an opcode is and what it uses.
  function automatic void classify(input logic [6:0] op, output logic legal, output logic u1,
                                   output logic u2, output logic wr, output logic mr,
                                   output logic mw, output byte fmt);
    legal = 1; u1 = 0; u2 = 0; wr = 0; mr = 0; mw = 0; fmt = "R";
    case (op)
      7'b0110111, 7'b0010111: begin wr = 1; fmt = "U"; end
      7'b1101111: begin wr = 1; fmt = "J"; end
      7'b1100111: begin wr = 1; u1 = 1; fmt = "I"; end
      7'b1100011: begin u1 = 1; u2 = 1; fmt = "B"; end
      7'b0000011: begin wr = 1; u1 = 1; mr = 1; fmt = "I"; end
      7'b0100011: begin u1 = 1; u2 = 1; mw = 1; fmt = "S"; end
      7'b0010011: begin wr = 1; u1 = 1; fmt = "I"; end
      7'b0110011: begin wr = 1; u1 = 1; u2 = 1; fmt = "R"; end
      default: legal = 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input byte fmt);
    case (fmt)
      "I": return sx({20'b0, ins[31:20]}, 11);
      "S": return sx({20'b0, ins[31:25], ins[11:7]}, 11);
      "B": return sx({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 12);
      "U": return {ins[31:12], 12'b0};
      "J": return sx({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 20);
      default: return 32'd0;
    endcase
  endfunction

  // One ID cycle: drive IF/ID at the falling edge, check stall_if, record expectation.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2,
                      output logic stl);
    logic legal, u1, u2, wr, mr, mw, hz;
    byte  fmt;
    int   rs1, rs2, rd;
    exp_t e;
    @(negedge CLK);
    if_id_valid = v; if_id_instr = ins; if_id_pc = pc; flush = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd; ReadData1 = r1; ReadData2 = r2;
    #1;
    classify(ins[6:0], legal, u1, u2, wr, mr, mw, fmt);
    rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]); rd = int'(ins[11:7]);
    chk("raddr", {ReadRegister1, ReadRegister2}, {22'b0, ins[19:15], ins[24:20]});
    hz  = v && m_ld_rd != 0 && ((u1 && rs1 == m_ld_rd) || (u2 && rs2 == m_ld_rd));
    stl = hz && !fl;
    chk("stall_if", stall_if, stl);
    m_ld_rd = 0;
    if (v && !fl && !hz) begin
      e = '{default: '0};
      e.pc = pc;
      if (legal) begin
        e.rs1v = (we && wrd != 0 && int'(wrd) == rs1) ? wd : r1;
        e.rs2v = (we && wrd != 0 && int'(wrd) == rs2) ? wd : r2;
        e.imm  = ref_imm(ins, fmt);
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7b5 = ins[30];
        e.rw = wr && rd != 0; e.mr = mr; e.mw = mw; e.dchk = 1;
        if (mr) m_ld_rd = rd;
      end else begin
        e.ill = 1;
      end
      q.push_back(e);
    end
    if (stl) m_stalls++;
    if (fl)  m_flushes++;
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] pc, input logic fl, output logic stl);
    step(1'b1, ins, pc, fl, 1'b0, 5'd0, 32'd0, $urandom, $urandom, stl);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; if_id_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 0);
    chk("rst_data", (|{ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode,
                       ex_funct3, ex_funct7b5}) ? 32'd1 : 32'd0, 0);
    chk("rst_stall", stall_if, 0);
    q.delete();
    m_ld_rd = 0; m_stalls = 0; m_flushes = 0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = int'($urandom_range(0, 10));
    w[6:0]   = (k == 10) ? 7'h7F : OPS[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Monitor: one expected entry per issued instruction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET) continue;
      if (ex_valid) begin
        if (q.size() == 0) begin
          chk("extra_issue", {ex_pc}, 32'hFFFF_FFFF ^ ex_pc);
        end else begin
          e = q.pop_front();
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_illegal", ex_illegal, e.ill);
          chk("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, {e.rw, e.mr, e.mw});
          if (e.dchk) begin
            chk("ex_rs1_val", ex_rs1_val, e.rs1v);
            chk("ex_rs2_val", ex_rs2_val, e.rs2v);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {e.rs1, e.rs2, e.rd});
            chk("ex_fields", {ex_opcode, ex_funct3, ex_funct7b5}, {e.op, e.f3, e.f7b5});
          end
        end
      end else begin
        chk("bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 0);
      end
    end
  end

  initial begin
    logic        stl, v, fl;
    logic [31:0] ins, pc;
    RESET = 1'b1; if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; flush = 0;
    ReadData1 = 0; ReadData2 = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("init_valid", ex_valid, 0);
    chk("init_stall", stall_if, 0);
    @(negedge CLK);
    RESET = 1'b0;

    go(32'h0050_0093, 32'h100, 0, stl);            // ADDI x1,x0,5
    after_edge();
    chk("addi_valid", ex_valid, 1);
    chk("addi_rd", ex_rd, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rw", ex_reg_write, 1);
    chk("addi_op", ex_opcode, 32'h13);

    go(32'hFE00_0EE3, 32'h104, 0, stl);            // BEQ x0,x0,-4
    after_edge();
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_rw", ex_reg_write, 0);

    go(32'h0010_0013, 32'h108, 0, stl);            // ADDI x0,x0,1
    after_edge();
    chk("x0_rw", ex_reg_write, 0);

    step(1, 32'h0031_8233, 32'h10C, 0, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, stl);  // ADD x4,x3,x3
    after_edge();
    chk("byp_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    chk("byp_rs2", ex_rs2_val, 32'hDEAD_BEEF);
    step(1, 32'h0031_8233, 32'h110, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, stl);
    after_edge();
    chk("byp_x0", ex_rs1_val | ex_rs2_val, 0);

    go(32'h0001_2283, 32'h114, 0, stl);            // LW x5,0(x2)
    go(32'h0012_8333, 32'h118, 0, stl);            // ADD x6,x5,x1
    chk("lu_stall", stall_if, 1);
    after_edge();
    chk("lu_bubble", ex_valid, 0);
    go(32'h0012_8333, 32'h118, 0, stl);
    chk("lu_release", stall_if, 0);
    after_edge();
    chk("lu_issue", ex_valid, 1);
    chk("lu_rs1", ex_rs1, 5);

    go(32'h0001_2283, 32'h200, 0, stl);            // LW x5 then flushed ADD
    go(32'h0012_8333, 32'h204, 1, stl);
    chk("flush_stall", stall_if, 0);
    after_edge();
    chk("flush_bubble", ex_valid, 0);
    go(32'h0010_0393, 32'h300, 0, stl);            // ADDI x7,x0,1

    go(32'h0000_007F, 32'h304, 0, stl);            // unsupported opcode
    after_edge();
    chk("ill_flag", {ex_valid, ex_illegal}, 2'b11);

    go(32'h0001_2283, 32'h308, 0, stl);            // in-flight LW when reset hits
    do_reset();

    for (int i = 0; i < 3; i++) begin
      go(32'h0001_2283, 32'h400, 0, stl);
      go(32'h0012_8333, 32'h404, 0, stl);
      go(32'h0012_8333, 32'h404, 0, stl);
    end
    go(32'h0010_0393, 32'h408, 1, stl);
    go(32'h0010_0393, 32'h40C, 1, stl);
    after_edge();
`ifdef DECODE_PERF_CNT_EN
    chk("perf_stall3", perf_stall_cnt, 3);
    chk("perf_flush2", perf_flush_cnt, 2);
`endif

    stl = 0; v = 0; ins = 0; pc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!stl) begin
        v   = ($urandom_range(0, 9) != 0);
        ins = rand_instr();
        pc  = $urandom & 32'hFFFF_FFFC;
      end
      fl = ($urandom_range(0, 11) == 0);
      step(v, ins, pc, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom, stl);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, stl);
    after_edge();
    chk("queue_empty", q.size(), 0);
`ifdef DECODE_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_stalls);
    chk("perf_flush", perf_flush_cnt, m_flushes);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
